// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: takes one command of up to MAX_BITS TMS/TDI bits, generates TCK,
// drives TMS/TDI to the TAP, captures TDO and returns it as a single response word.
module jtag_shift_engine #(
    parameter int CLK_DIV     = 4,
    parameter int MAX_BITS    = 32,
    parameter int TRST_CYCLES = 8
) (
    input  logic                ps7_clk,
    input  logic                ps7_rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_trst_i,
    input  logic [5:0]          cmd_len_i,
    input  logic [MAX_BITS-1:0] cmd_tms_i,
    input  logic [MAX_BITS-1:0] cmd_tdi_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MAX_BITS-1:0] rsp_tdo_o,
    output logic                busy_o,
    output logic                tck_o,
    output logic                trst_no,
    output logic                tms_o,
    output logic                tdi_o,
    input  logic                tdo_i
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(MAX_BITS);
    localparam int TW = $clog2(TRST_CYCLES + 1);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("jtag_shift_engine: CLK_DIV must be >= 4");
    end

    typedef enum logic [2:0] {IDLE, TRST, LOW, HIGH, DONE} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [TW-1:0]       trst_cnt_q, trst_cnt_d;
    logic [5:0]          idx_q, idx_d, idx_inc;
    logic [5:0]          len_q, len_d, len_clamp;
    logic [MAX_BITS-1:0] tms_q, tms_d, tdi_q, tdi_d, rsp_tdo_d;
    logic                tms_bit_d, tdi_bit_d;
    logic                tck_d, trst_n_d, ready_d, rsp_valid_d, busy_d;
    logic                tdo_meta_q, tdo_sync_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        trst_cnt_d  = trst_cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_tdo_d   = rsp_tdo_o;
        tms_bit_d   = tms_o;
        tdi_bit_d   = tdi_o;
        idx_inc     = idx_q + 6'd1;
        len_clamp   = (cmd_len_i > 6'(MAX_BITS)) ? 6'(MAX_BITS) : cmd_len_i;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    len_d      = len_clamp;
                    tms_d      = cmd_tms_i;
                    tdi_d      = cmd_tdi_i;
                    rsp_tdo_d  = '0;
                    idx_d      = '0;
                    div_d      = '0;
                    trst_cnt_d = '0;
                    if (cmd_trst_i) begin
                        state_d   = TRST;
                        tms_bit_d = 1'b1;
                    end else if (len_clamp != 6'd0) begin
                        state_d   = LOW;
                        tms_bit_d = cmd_tms_i[0];
                        tdi_bit_d = cmd_tdi_i[0];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            TRST: begin
                if (trst_cnt_q == TW'(TRST_CYCLES - 1)) begin
                    if (len_q != 6'd0) begin
                        state_d   = LOW;
                        tms_bit_d = tms_q[0];
                        tdi_bit_d = tdi_q[0];
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    trst_cnt_d = trst_cnt_q + TW'(1);
                end
            end
            LOW: begin
                // TDO is sampled as late as possible in the low phase so the
                // two-flop synchroniser has settled on the TAP's output.
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d                    = '0;
                    rsp_tdo_d[idx_q[BW-1:0]] = tdo_sync_q;
                    state_d                  = HIGH;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            HIGH: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = DONE;
                    end else begin
                        state_d   = LOW;
                        tms_bit_d = tms_q[idx_inc[BW-1:0]];
                        tdi_bit_d = tdi_q[idx_inc[BW-1:0]];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every port-level strobe is a pure function of the next state, so
        // registering them keeps outputs glitch-free and aligned with the FSM.
        tck_d       = (state_d == HIGH);
        trst_n_d    = (state_d != TRST);
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            trst_cnt_q  <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            tms_q       <= '0;
            tdi_q       <= '0;
            rsp_tdo_o   <= '0;
            tck_o       <= 1'b0;
            trst_no     <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            tdo_meta_q  <= 1'b0;
            tdo_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            trst_cnt_q  <= trst_cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_tdo_o   <= rsp_tdo_d;
            tck_o       <= tck_d;
            trst_no     <= trst_n_d;
            tms_o       <= tms_bit_d;
            tdi_o       <= tdi_bit_d;
            cmd_ready_o <= ready_d;
            rsp_valid_o <= rsp_valid_d;
            busy_o      <= busy_d;
            tdo_meta_q  <= tdo_i;
            tdo_sync_q  <= tdo_meta_q;
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine with TDO looped back from TDI.
module tb_jtag_shift_engine;

    logic        ps7_clk;
    logic        ps7_rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_trst_i;
    logic [5:0]  cmd_len_i;
    logic [31:0] cmd_tms_i;
    logic [31:0] cmd_tdi_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_tdo_o;
    logic        busy_o;
    logic        tck_o;
    logic        trst_no;
    logic        tms_o;
    logic        tdi_o;
    logic        tdo_i;

    int n_tests = 0;
    int n_fail  = 0;
    int tck_rises = 0;
    int trst_low_cycles = 0;
    int trst_tms_low = 0;

    assign tdo_i = tdi_o;

    jtag_shift_engine #(.CLK_DIV(4), .MAX_BITS(32), .TRST_CYCLES(8)) dut (
        .ps7_clk    (ps7_clk),
        .ps7_rst_n  (ps7_rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_trst_i (cmd_trst_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_tms_i  (cmd_tms_i),
        .cmd_tdi_i  (cmd_tdi_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_tdo_o  (rsp_tdo_o),
        .busy_o     (busy_o),
        .tck_o      (tck_o),
        .trst_no    (trst_no),
        .tms_o      (tms_o),
        .tdi_o      (tdi_o),
        .tdo_i      (tdo_i)
    );

    initial ps7_clk = 1'b0;
    always #5 ps7_clk = ~ps7_clk;

    always @(posedge tck_o) tck_rises++;

    always @(posedge ps7_clk) begin
        if (!trst_no) begin
            trst_low_cycles++;
            if (!tms_o) trst_tms_low++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ps7_clk);
        #1;
    endtask

    task automatic send_cmd(input logic trst, input logic [5:0] len,
                            input logic [31:0] tms, input logic [31:0] tdi);
        int w;
        w = 0;
        while (!cmd_ready_o && w < 100) begin
            tick();
            w++;
        end
        check("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_trst_i  = trst;
        cmd_len_i   = len;
        cmd_tms_i   = tms;
        cmd_tdi_i   = tdi;
        tick();
        cmd_valid_i = 1'b0;
        cmd_trst_i  = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid_o && cycles < 5000) begin
            tick();
            cycles++;
        end
        check("rsp_valid_timeout", 32'(rsp_valid_o), 32'd1);
    endtask

    task automatic ack_rsp();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("ack_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("ack_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("ack_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int tck0;
        int trst0;
        int tmsl0;

        ps7_rst_n   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_trst_i  = 1'b0;
        cmd_len_i   = '0;
        cmd_tms_i   = '0;
        cmd_tdi_i   = '0;
        rsp_ready_i = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_tck", 32'(tck_o), 32'd0);
        check("rst_trst_n", 32'(trst_no), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("rst_tms", 32'(tms_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rsp_tdo", rsp_tdo_o, 32'd0);
        ps7_rst_n = 1'b1;
        tick();
        check("rel_trst_n", 32'(trst_no), 32'd1);
        check("rel_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // TRST with zero-length shift
        tck0 = tck_rises; trst0 = trst_low_cycles; tmsl0 = trst_tms_low;
        send_cmd(1'b1, 6'd0, 32'h0, 32'h0);
        check("trst_busy", 32'(busy_o), 32'd1);
        check("trst_pin_low", 32'(trst_no), 32'd0);
        wait_rsp(cyc);
        check("trst_cycles_to_rsp", 32'(cyc), 32'd8);
        check("trst_low_cycles", 32'(trst_low_cycles - trst0), 32'd8);
        check("trst_tms_high", 32'(trst_tms_low - tmsl0), 32'd0);
        check("trst_no_tck", 32'(tck_rises - tck0), 32'd0);
        check("trst_pin_released", 32'(trst_no), 32'd1);
        check("trst_rsp_tdo", rsp_tdo_o, 32'd0);
        ack_rsp();

        // Loopback, 8 bits
        tck0 = tck_rises;
        send_cmd(1'b0, 6'd8, 32'h0000_0003, 32'hDEAD_BEA5);
        wait_rsp(cyc);
        check("len8_cycles", 32'(cyc), 32'd64);
        check("len8_tck_rises", 32'(tck_rises - tck0), 32'd8);
        check("len8_rsp_tdo", rsp_tdo_o, 32'h0000_00A5);
        check("len8_tdi_hold", 32'(tdi_o), 32'd1);
        check("len8_tms_hold", 32'(tms_o), 32'd0);
        check("len8_tck_low", 32'(tck_o), 32'd0);
        ack_rsp();

        // Loopback, length 40 clamped to 32
        tck0 = tck_rises;
        send_cmd(1'b0, 6'd40, 32'hFFFF_0000, 32'hDEAD_BEEF);
        wait_rsp(cyc);
        check("len40_cycles", 32'(cyc), 32'd256);
        check("len40_tck_rises", 32'(tck_rises - tck0), 32'd32);
        check("len40_rsp_tdo", rsp_tdo_o, 32'hDEAD_BEEF);
        check("len40_tms_hold", 32'(tms_o), 32'd1);

        // Response held while not consumed; new command ignored
        cmd_valid_i = 1'b1;
        cmd_len_i   = 6'd5;
        cmd_tms_i   = 32'h0;
        cmd_tdi_i   = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_rsp_tdo", rsp_tdo_o, 32'hDEAD_BEEF);
            check("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
        end
        check("hold_no_tck", 32'(tck_rises - tck0), 32'd32);
        cmd_valid_i = 1'b0;
        ack_rsp();

        // Asynchronous reset during bit 3
        send_cmd(1'b0, 6'd8, 32'h0000_0000, 32'h0000_00FF);
        repeat (26) tick();
        check("midrst_busy_before", 32'(busy_o), 32'd1);
        ps7_rst_n = 1'b0;
        #1;
        check("midrst_tck", 32'(tck_o), 32'd0);
        check("midrst_trst_n", 32'(trst_no), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_tms", 32'(tms_o), 32'd1);
        check("midrst_tdi", 32'(tdi_o), 32'd0);
        check("midrst_rsp_tdo", rsp_tdo_o, 32'd0);
        tick();
        ps7_rst_n = 1'b1;
        tick();
        check("midrel_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("midrel_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrel_trst_n", 32'(trst_no), 32'd1);

        // Short command after recovery
        tck0 = tck_rises;
        send_cmd(1'b0, 6'd4, 32'h0000_000F, 32'h0000_0005);
        wait_rsp(cyc);
        check("len4_cycles", 32'(cyc), 32'd32);
        check("len4_tck_rises", 32'(tck_rises - tck0), 32'd4);
        check("len4_rsp_tdo", rsp_tdo_o, 32'h0000_0005);
        check("len4_tms_hold", 32'(tms_o), 32'd1);
        ack_rsp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
